// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, key-schedule sizes, FSM encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: NK/NR/NW schedule sizes, RK_MAX read-index limit, state_t (IDLE/EXPAND/DONE),
//           SBOX table with sbox() lookup, RCON table, rot_word() helper.
package aes_pkg;

   // AES-256 only: the schedule datapath below assumes an 8-word key.
   localparam int NK = 8;
   localparam int NR = 14;
   localparam int NW = 4 * (NR + 1);

   // Highest legal round-key index.
   localparam logic [3:0] RK_MAX = 4'(NR);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Indexed by i/8; entry 0 is never used because the first derived word is w8.
   localparam logic [7:0] RCON [0:7] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[a];
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] t);
      return {t[23:0], t[31:24]};
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: AES S-box applied to each byte of a 32-bit word (shared with the round datapath).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports: i_word (32, in) word to substitute; o_word (32, out) substituted word.
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);

   assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                    sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES-256 key expansion: loads an 8-word key, derives w8..w59 one word per clock into a register file.
// Latency: start sampled at edge 0, key loaded at edge 1, w59 at edge 53, done pulse after edge 53.
// Backpressure: none; start is ignored while busy, readers must gate on keys_valid.
// Ports: clk, rst (async active-low), key_in[255:0] (w0 in [255:224]), start, rk_idx[3:0],
//        rk_out[127:0] (combinational round-key read, zero for idx>14), busy, done, keys_valid.
// Optional macro AES_KEYEXP_STREAM_EN adds rk_stream_valid, rk_stream[127:0], rk_stream_idx[3:0],
// which present each round key as soon as its last word is written.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] key_in,
   input  logic         start,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out,
   output logic         busy,
   output logic         done,
   output logic         keys_valid
`ifdef AES_KEYEXP_STREAM_EN
   ,
   output logic         rk_stream_valid,
   output logic [127:0] rk_stream,
   output logic [3:0]   rk_stream_idx
`endif
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [5:0]    r_i;
   logic [31:0]   r_w [0:NW-1];
   logic          r_start;
   logic          r_done;

   logic          w_load;
   logic          w_write;
   logic          w_last;
   logic [31:0]   w_t;
   logic [31:0]   w_back;
   logic [31:0]   w_sub_in;
   logic [31:0]   w_sub_out;
   logic [31:0]   w_tx;
   logic [31:0]   w_new;
   logic [7:0]    w_rcon;

   function automatic logic [127:0] read_rk(input logic [3:0] k);
      logic [5:0] b;
      b = {k, 2'b00};
      return {r_w[b], r_w[b | 6'd1], r_w[b | 6'd2], r_w[b | 6'd3]};
   endfunction

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_write     = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (r_start) begin
               w_load      = 1'b1;
               w_state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            w_write = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_last = (r_i == 6'(NW - 1));

   // start is registered once; a request seen while expanding is dropped here so it
   // cannot fire a reload on the cycle the FSM reaches DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_start <= 1'b0;
         r_done  <= 1'b0;
         r_i     <= 6'(NK);
      end else begin
         r_start <= start & (r_state != EXPAND);
         r_done  <= w_write & w_last;
         if (w_load) begin
            r_i <= 6'(NK);
         end else if (w_write && !w_last) begin
            r_i <= r_i + 6'd1;
         end
      end
   end

   // ---------------- word datapath ----------------
   assign w_t      = r_w[r_i - 6'd1];
   assign w_back   = r_w[r_i - 6'd8];
   assign w_sub_in = (r_i[2:0] == 3'd0) ? rot_word(w_t) : w_t;
   assign w_rcon   = RCON[r_i[5:3]];

   aes_subword u_subword (
      .i_word (w_sub_in),
      .o_word (w_sub_out)
   );

   always_comb begin
      w_tx = w_t;
      case (r_i[2:0])
         3'd0:    w_tx = w_sub_out ^ {w_rcon, 24'h0};
         3'd4:    w_tx = w_sub_out;
         default: w_tx = w_t;
      endcase
   end

   assign w_new = w_back ^ w_tx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NW; k++) begin
            r_w[k] <= '0;
         end
      end else if (w_load) begin
         for (int k = 0; k < NK; k++) begin
            r_w[k] <= key_in[255 - 32*k -: 32];
         end
      end else if (w_write) begin
         r_w[r_i] <= w_new;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      rk_out = '0;
      if (rk_idx <= RK_MAX) begin
         rk_out = read_rk(rk_idx);
      end
   end

   assign busy       = (r_state == EXPAND);
   assign keys_valid = (r_state == DONE);
   assign done       = r_done;

`ifdef AES_KEYEXP_STREAM_EN
   logic       r_sv;
   logic [3:0] r_sidx;

   // Keys 0 and 1 both complete at the load edge; key 1 is deferred one cycle so
   // every key gets its own pulse. No later key completes on the w8 edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sv   <= 1'b0;
         r_sidx <= 4'd0;
      end else begin
         r_sv <= 1'b0;
         if (w_load) begin
            r_sv   <= 1'b1;
            r_sidx <= 4'd0;
         end else if (w_write && r_i == 6'(NK)) begin
            r_sv   <= 1'b1;
            r_sidx <= 4'd1;
         end else if (w_write && r_i[1:0] == 2'b11) begin
            r_sv   <= 1'b1;
            r_sidx <= r_i[5:2];
         end
      end
   end

   assign rk_stream_valid = r_sv;
   assign rk_stream_idx   = r_sidx;
   assign rk_stream       = read_rk(r_sidx);
`endif

endmodule
